// File: rtl/ttl_pkg.sv
// Shared TTL-library definitions: bank modes and the JK function table.
package ttl_pkg;

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // JK function table, indexed by {J,K}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic r;
    case ({j, k})
      JK_HOLD:  r = q;
      JK_RESET: r = 1'b0;
      JK_SET:   r = 1'b1;
      default:  r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ttl_jk_cell.sv
// One JK channel: q/inv state, preset/clear priority, JK or toggle-request update.
module ttl_jk_cell
  import ttl_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       pre_n,
  input  logic       clr_n,
  input  logic       tog,
  output logic       q_state,
  output logic       q,
  output logic       qn
);

  logic q_r, inv_r, q_nx, inv_nx;

  always_comb begin
    q_nx   = q_r;
    inv_nx = 1'b0;
    // both overrides together keep q and force Q/QN high
    if (!pre_n && !clr_n) inv_nx = 1'b1;
    else if (!pre_n)      q_nx   = 1'b1;
    else if (!clr_n)      q_nx   = 1'b0;
    else if (en) begin
      case (mode)
        MODE_JK:          q_nx = jk_next(j, k, q_r);
        MODE_UP, MODE_DN: q_nx = q_r ^ tog;
        default:          q_nx = q_r;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= RESET_BIT;
      inv_r <= 1'b0;
    end else begin
      q_r   <= q_nx;
      inv_r <= inv_nx;
    end
  end

  assign q_state = q_r;
  assign q       = inv_r | q_r;
  assign qn      = inv_r | ~q_r;

endmodule

// File: rtl/ttl_jk_bank.sv
// Bank of WIDTH falling-edge JK channels with optional up/down counter chain.
// Counter mode and RCO are compiled only when JK_BANK_COUNT_EN is defined.
module ttl_jk_bank
  import ttl_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] PRE_N,
  input  logic [WIDTH-1:0] CLR_N,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             RCO
);

  logic [WIDTH-1:0] tog;

`ifdef JK_BANK_COUNT_EN
  logic [WIDTH-1:0] q_state;
  logic [WIDTH:0]   all1, all0;

  // chain runs on stored q so overridden channels don't disturb the count
  assign all1[0] = 1'b1;
  assign all0[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign all1[i+1] = all1[i] & q_state[i];
    assign all0[i+1] = all0[i] & ~q_state[i];
    assign tog[i]    = (MODE == MODE_UP) ? all1[i] :
                       (MODE == MODE_DN) ? all0[i] : 1'b0;
  end

  assign RCO = ~RST & EN & (((MODE == MODE_UP) & all1[WIDTH]) |
                            ((MODE == MODE_DN) & all0[WIDTH]));
`else
  assign tog = '0;
  assign RCO = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ttl_jk_cell #(.RESET_BIT(RESET_VAL[i])) u_cell (
      .clk    (CLK),
      .rst    (RST),
      .en     (EN),
      .mode   (MODE),
      .j      (J[i]),
      .k      (K[i]),
      .pre_n  (PRE_N[i]),
      .clr_n  (CLR_N[i]),
      .tog    (tog[i]),
`ifdef JK_BANK_COUNT_EN
      .q_state(q_state[i]),
`else
      .q_state(),
`endif
      .q      (Q[i]),
      .qn     (QN[i])
    );
  end

endmodule
